// File: rtl/spike_window_counter.sv
// spike_window_counter: counts spikes per neuron over back-to-back windows of
// L cycles with saturating counters. Each completed window is presented on a
// valid/ready output. A window that completes while the previous result is
// still held is dropped, and the sticky overrun flag is set.
module spike_window_counter #(
  parameter int NUM_NEURONS = 8,
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [WIN_W-1:0]             win_len,
  input  logic [NUM_NEURONS-1:0]       spike_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_NEURONS*CNT_W-1:0] out_counts,
  output logic [7:0]                   out_win_id,
  output logic                         overrun
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                         state;
  logic [WIN_W-1:0]               len_q;
  logic [WIN_W-1:0]               phase;
  logic [NUM_NEURONS*CNT_W-1:0]   acc;
  logic [NUM_NEURONS*CNT_W-1:0]   acc_next;
  logic [7:0]                     win_cnt;
  logic [WIN_W-1:0]               len_eff;
  logic                           win_end;
  logic                           accept;
  logic                           load;

  // Saturating per-neuron accumulate of this edge's spike sample
  always_comb begin
    acc_next = '0;
    for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
      if (spike_in[n] && (acc[n*CNT_W +: CNT_W] != CNT_MAX))
        acc_next[n*CNT_W +: CNT_W] = acc[n*CNT_W +: CNT_W] + CNT_W'(1);
      else
        acc_next[n*CNT_W +: CNT_W] = acc[n*CNT_W +: CNT_W];
    end
  end

  // Window-end and handshake decode; a zero window length counts as one cycle
  always_comb begin
    len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    win_end = (state == COUNT) && (phase == (len_q - WIN_W'(1)));
    accept  = out_valid && out_ready;
    load    = win_end && (!out_valid || out_ready);
  end

  // Window sequencing, result register and output handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= WIN_W'(1);
      phase      <= '0;
      acc        <= '0;
      win_cnt    <= '0;
      out_valid  <= 1'b0;
      out_counts <= '0;
      out_win_id <= '0;
      overrun    <= 1'b0;
    end else begin
      // A load later in this block overrides the accept-driven clear
      if (accept)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            len_q <= len_eff;
            phase <= '0;
            acc   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          // Window end takes priority over an enable drop on the same edge
          if (win_end) begin
            if (load) begin
              out_counts <= acc_next;
              out_win_id <= win_cnt;
              out_valid  <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            win_cnt <= win_cnt + 8'd1;
            acc     <= '0;
            phase   <= '0;
            len_q   <= len_eff;
            state   <= enable ? COUNT : IDLE;
          end else if (!enable) begin
            acc   <= '0;
            phase <= '0;
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            phase <= phase + WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
// Testbench for spike_window_counter: scenario stimulus pushes the results it
// expects into a queue; a monitor pops and compares each result as it is
// accepted on the output handshake.
module tb_spike_window_counter;

  localparam int N  = 8;
  localparam int CW = 8;
  localparam int WW = 16;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [WW-1:0]   win_len;
  logic [N-1:0]    spike_in;
  logic            out_valid;
  logic            out_ready;
  logic [N*CW-1:0] out_counts;
  logic [7:0]      out_win_id;
  logic            overrun;

  spike_window_counter #(
    .NUM_NEURONS(N),
    .CNT_W      (CW),
    .WIN_W      (WW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .win_len   (win_len),
    .spike_in  (spike_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_counts(out_counts),
    .out_win_id(out_win_id),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*CW-1:0] counts;
    logic [7:0]      id;
  } res_t;

  res_t exp_q[$];
  res_t exp_r;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*CW-1:0] rep(input logic [N-1:0] mask, input logic [CW-1:0] v);
    logic [N*CW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (mask[i]) r[i*CW +: CW] = v;
    return r;
  endfunction

  task automatic push(input logic [N-1:0] mask, input logic [CW-1:0] v, input logic [7:0] id);
    res_t e;
    e.counts = rep(mask, v);
    e.id     = id;
    exp_q.push_back(e);
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   out_valid,  0);
    check({tag, "_counts"},  out_counts, 0);
    check({tag, "_win_id"},  out_win_id, 0);
    check({tag, "_overrun"}, overrun,    0);
  endtask

  task automatic do_reset();
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
    enable    = 1'b0;
    out_ready = 1'b0;
    spike_in  = '0;
    reset     = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Scoreboard: each result accepted on an edge is popped and compared
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_r = exp_q.pop_front();
        check("sb_counts", out_counts, exp_r.counts);
        check("sb_win_id", out_win_id, exp_r.id);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    win_len   = '0;
    spike_in  = '0;
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("init");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Basic count: L=10, neurons 0 and 2 spike continuously
    win_len = 16'd10; spike_in = 8'h05; out_ready = 1'b1; enable = 1'b1;
    push(8'h05, 8'd10, 8'd0);
    push(8'h05, 8'd10, 8'd1);
    adv(10);
    check("basic_valid_pre", out_valid, 0);
    adv(1);
    check("basic_valid_w0", out_valid, 1);
    adv(1);
    check("basic_valid_pulse", out_valid, 0);
    adv(8);
    check("basic_valid_gap", out_valid, 0);
    adv(1);
    check("basic_valid_w1", out_valid, 1);
    enable = 1'b0;
    adv(1);
    check("basic_valid_end", out_valid, 0);
    check("basic_overrun", overrun, 0);

    // Saturation: L=300, all neurons spike every cycle
    do_reset();
    win_len = 16'd300; spike_in = 8'hFF; out_ready = 1'b1; enable = 1'b1;
    push(8'hFF, 8'd255, 8'd0);
    adv(300);
    check("sat_valid_pre", out_valid, 0);
    adv(1);
    check("sat_valid", out_valid, 1);
    check("sat_overrun", overrun, 0);
    enable = 1'b0;
    adv(1);

    // Backpressure: windows 1 and 2 dropped while result 0 is held
    do_reset();
    win_len = 16'd4; spike_in = 8'h81; out_ready = 1'b0; enable = 1'b1;
    push(8'h81, 8'd4, 8'd0);
    push(8'h81, 8'd4, 8'd3);
    adv(5);
    check("bp_valid", out_valid, 1);
    check("bp_id0", out_win_id, 0);
    check("bp_counts0", out_counts, rep(8'h81, 8'd4));
    adv(3);
    check("bp_overrun_pre", overrun, 0);
    adv(1);
    check("bp_overrun_set", overrun, 1);
    check("bp_hold_id", out_win_id, 0);
    check("bp_hold_counts", out_counts, rep(8'h81, 8'd4));
    adv(4);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_id2", out_win_id, 0);
    out_ready = 1'b1;
    adv(1);
    check("bp_accepted", out_valid, 0);
    adv(3);
    check("bp_valid3", out_valid, 1);
    check("bp_id3", out_win_id, 3);
    enable = 1'b0;
    adv(3);
    check("bp_overrun_sticky", overrun, 1);

    // Same-edge accept+load: L=1, bit0 alternates 1,0
    do_reset();
    win_len = 16'd1; out_ready = 1'b1; spike_in = 8'h00; enable = 1'b1;
    adv(1);
    for (int k = 1; k <= 9; k++) begin
      spike_in = (k % 2 == 1) ? 8'h01 : 8'h00;
      push(8'h01, (k % 2 == 1) ? 8'd1 : 8'd0, 8'(k - 1));
      if (k == 9) enable = 1'b0;
      adv(1);
      check("l1_valid", out_valid, 1);
    end
    adv(1);
    check("l1_valid_end", out_valid, 0);
    check("l1_overrun", overrun, 0);

    // Enable abort: partial window discarded, id unchanged, len change ignored
    do_reset();
    win_len = 16'd8; out_ready = 1'b1; spike_in = 8'h04; enable = 1'b1;
    push(8'h04, 8'd8, 8'd0);
    adv(9);
    check("ab_valid_w0", out_valid, 1);
    spike_in = 8'h02;
    adv(5);
    check("ab_valid_mid", out_valid, 0);
    enable = 1'b0;
    adv(3);
    check("ab_no_event", out_valid, 0);
    spike_in = 8'h10; enable = 1'b1;
    push(8'h10, 8'd8, 8'd1);
    adv(1);
    win_len = 16'd3;
    adv(7);
    check("ab_len_change_ignored", out_valid, 0);
    adv(1);
    check("ab_valid_w1", out_valid, 1);
    check("ab_id1", out_win_id, 1);
    enable = 1'b0;
    adv(1);
    check("ab_overrun", overrun, 0);

    // Async reset mid-window while a result is held and overrun is set
    do_reset();
    win_len = 16'd3; out_ready = 1'b1; spike_in = 8'hFF; enable = 1'b1;
    push(8'hFF, 8'd3, 8'd0);
    adv(4);
    check("ar_valid0", out_valid, 1);
    adv(1);
    out_ready = 1'b0;
    adv(5);
    check("ar_valid1", out_valid, 1);
    check("ar_id1", out_win_id, 1);
    check("ar_overrun", overrun, 1);
    adv(1);
    check("q_empty", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("ar_async");
    @(posedge clk);
    #2;
    reset = 1'b0;
    out_ready = 1'b1; spike_in = 8'h01;
    push(8'h01, 8'd3, 8'd0);
    adv(4);
    check("ar_post_valid", out_valid, 1);
    check("ar_post_id", out_win_id, 0);
    enable = 1'b0;
    adv(1);
    check("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
